// File: rtl/rf_scoreboard.sv
// rf_scoreboard: two-write/two-read register file with bypass, a per-entry pending (busy) scoreboard and a pending count.
module rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              iss_v,
  input  logic [ADDR_W-1:0] iss_a,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nx;
  logic [ADDR_W:0]   cnt_nx;
  logic              wv0, wv1;
  assign wv0 = we0 && wa0 != '0;
  assign wv1 = we1 && wa1 != '0;
  assign rd1 = ra1 == '0 ? '0 : (we1 && wa1 == ra1) ? wd1 : (we0 && wa0 == ra1) ? wd0 : mem[ra1];
  assign rd2 = ra2 == '0 ? '0 : (we1 && wa1 == ra2) ? wd1 : (we0 && wa0 == ra2) ? wd0 : mem[ra2];
  assign busy1 = ra1 != '0 && busy[ra1] && !(we0 && wa0 == ra1) && !(we1 && wa1 == ra1);
  assign busy2 = ra2 != '0 && busy[ra2] && !(we0 && wa0 == ra2) && !(we1 && wa1 == ra2);
  assign stall = busy1 || busy2;
  assign dbg_data = dbg_sel == '0 ? '0 : mem[dbg_sel];
  always_comb begin
    busy_nx = busy;
    if (wv0) busy_nx[wa0] = 1'b0;
    if (wv1) busy_nx[wa1] = 1'b0;
    if (iss_v && iss_a != '0) busy_nx[iss_a] = 1'b1;
    busy_nx[0] = 1'b0;
    cnt_nx = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nx = cnt_nx + (ADDR_W+1)'(busy_nx[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wv0) mem[wa0] <= wd0;
      if (wv1) mem[wa1] <= wd1;
      busy     <= busy_nx;
      pend_cnt <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed self-checking bench for rf_scoreboard.
module tb_rf_scoreboard;
  logic        clk = 0, rst = 1;
  logic        we0 = 0, we1 = 0, iss_v = 0;
  logic [4:0]  wa0 = 0, wa1 = 0, ra1 = 0, ra2 = 0, iss_a = 0, dbg_sel = 0;
  logic [31:0] wd0 = 0, wd1 = 0;
  logic [31:0] rd1, rd2, dbg_data;
  logic        busy1, busy2, stall;
  logic [5:0]  pend_cnt;
  int checks = 0, errors = 0;
  rf_scoreboard dut (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .iss_v(iss_v), .iss_a(iss_a),
    .busy1(busy1), .busy2(busy2), .stall(stall), .pend_cnt(pend_cnt),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    we0 = 0; we1 = 0; iss_v = 0; rst = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1[%0d]: got %h exp 0", i, rd1); end
      checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2[%0d]: got %h exp 0", i, rd2); end
      checks++; if ({busy1, busy2} !== 2'b00) begin errors++; $display("FAIL reset_busy[%0d]: got %b exp 00", i, {busy1, busy2}); end
    end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_pend: got %0d exp 0", pend_cnt); end
  endtask
  task automatic test_write_bypass;
    we0 = 1; wa0 = 5; wd0 = 32'h1234; ra1 = 5; ra2 = 6; dbg_sel = 5;
    #1;
    checks++; if (rd1 !== 32'h1234) begin errors++; $display("FAIL bypass_rd1: got %h exp 1234", rd1); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL bypass_rd2: got %h exp 0", rd2); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL dbg_no_bypass: got %h exp 0", dbg_data); end
    tick();
    idle();
    #1;
    checks++; if (rd1 !== 32'h1234) begin errors++; $display("FAIL stored_rd1: got %h exp 1234", rd1); end
    checks++; if (dbg_data !== 32'h1234) begin errors++; $display("FAIL stored_dbg: got %h exp 1234", dbg_data); end
  endtask
  task automatic test_same_addr;
    we0 = 1; wa0 = 7; wd0 = 32'hAAAA; we1 = 1; wa1 = 7; wd1 = 32'h5555; ra1 = 7; ra2 = 5; dbg_sel = 7;
    #1;
    checks++; if (rd1 !== 32'h5555) begin errors++; $display("FAIL prio_comb_rd1: got %h exp 5555", rd1); end
    checks++; if (rd2 !== 32'h1234) begin errors++; $display("FAIL prio_comb_rd2: got %h exp 1234", rd2); end
    tick();
    idle();
    #1;
    checks++; if (rd1 !== 32'h5555) begin errors++; $display("FAIL prio_stored_rd1: got %h exp 5555", rd1); end
    checks++; if (dbg_data !== 32'h5555) begin errors++; $display("FAIL prio_stored_dbg: got %h exp 5555", dbg_data); end
  endtask
  task automatic test_issue;
    iss_v = 1; iss_a = 3;
    tick();
    idle(); ra1 = 3; ra2 = 0;
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL issue_busy1: got %b exp 1", busy1); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL issue_stall: got %b exp 1", stall); end
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL issue_pend: got %0d exp 1", pend_cnt); end
    we1 = 1; wa1 = 3; wd1 = 32'h33;
    #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL wb_busy1: got %b exp 0", busy1); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_stall: got %b exp 0", stall); end
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL wb_pend: got %0d exp 0", pend_cnt); end
    checks++; if (rd1 !== 32'h33) begin errors++; $display("FAIL wb_rd1: got %h exp 33", rd1); end
  endtask
  task automatic test_issue_wb_same;
    iss_v = 1; iss_a = 4;
    tick();
    iss_v = 1; iss_a = 4; we0 = 1; wa0 = 4; wd0 = 32'h44;
    tick();
    idle(); ra1 = 4;
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL newprod_busy1: got %b exp 1", busy1); end
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL newprod_pend: got %0d exp 1", pend_cnt); end
    checks++; if (rd1 !== 32'h44) begin errors++; $display("FAIL newprod_rd1: got %h exp 44", rd1); end
    we0 = 1; wa0 = 4; wd0 = 32'h45;
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL newprod_clear_pend: got %0d exp 0", pend_cnt); end
  endtask
  task automatic test_zero;
    iss_v = 1; iss_a = 9;
    tick();
    idle();
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF; iss_v = 1; iss_a = 0; ra1 = 0; dbg_sel = 0;
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_rd1: got %h exp 0", rd1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy1: got %b exp 0", busy1); end
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL zero_pend: got %0d exp 1", pend_cnt); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL zero_dbg: got %h exp 0", dbg_data); end
    iss_v = 1; iss_a = 9;
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL reissue_pend: got %0d exp 1", pend_cnt); end
  endtask
  task automatic test_back_to_back;
    iss_v = 1; iss_a = 10;
    tick();
    iss_a = 11;
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd3) begin errors++; $display("FAIL b2b_pend3: got %0d exp 3", pend_cnt); end
    ra1 = 10; ra2 = 11;
    #1;
    checks++; if ({busy1, busy2} !== 2'b11) begin errors++; $display("FAIL b2b_busy_pre: got %b exp 11", {busy1, busy2}); end
    we0 = 1; wa0 = 10; wd0 = 32'hA0; we1 = 1; wa1 = 11; wd1 = 32'hB0;
    #1;
    checks++; if ({busy1, busy2} !== 2'b00) begin errors++; $display("FAIL b2b_busy_wb: got %b exp 00", {busy1, busy2}); end
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL b2b_pend1: got %0d exp 1", pend_cnt); end
    checks++; if ({rd1, rd2} !== {32'hA0, 32'hB0}) begin errors++; $display("FAIL b2b_rd: got %h %h exp a0 b0", rd1, rd2); end
    we0 = 1; wa0 = 12; we1 = 0;
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL wb_nonbusy_pend: got %0d exp 1", pend_cnt); end
  endtask
  task automatic test_reset_mid;
    iss_v = 1; iss_a = 12;
    tick();
    iss_a = 13;
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd3) begin errors++; $display("FAIL mid_pend3: got %0d exp 3", pend_cnt); end
    rst = 1; we0 = 1; wa0 = 6; wd0 = 32'h66; iss_v = 1; iss_a = 14; ra1 = 6;
    #1;
    checks++; if (rd1 !== 32'h66) begin errors++; $display("FAIL rst_bypass_rd1: got %h exp 66", rd1); end
    tick();
    idle(); ra1 = 9; dbg_sel = 5;
    #1;
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL mid_pend0: got %0d exp 0", pend_cnt); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_busy1: got %b exp 0", busy1); end
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL mid_dbg5: got %h exp 0", dbg_data); end
    dbg_sel = 6;
    #1;
    checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL mid_dbg6: got %h exp 0", dbg_data); end
    iss_v = 1; iss_a = 2;
    tick();
    idle();
    #1;
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL post_rst_pend: got %0d exp 1", pend_cnt); end
  endtask
  initial begin
    test_reset();
    test_write_bypass();
    test_same_addr();
    test_issue();
    test_issue_wb_same();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
